edge_detect: RTL and testbench

Transition detector on the USB D+ receive line. Registers d_plus every clock and pulses d_edge for one cycle whenever the registered line value differs from its value one cycle earlier. Sits at the front of the USB RX path and feeds edge events to the bit-timing/clock-recovery logic, which resynchronises its sample point on each pulse. Also exposes rise/fall qualifiers and the registered line level for downstream decode.

---
 rtl/edge_detect.sv | 59 +++++
 tb/tb_edge_detect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
//
// Transition detector for the USB D+ receive line. The line is registered
// every clock into a two-deep history (cur_q, prev_q), and the outputs are
// decoded from that history only. There is no combinational path from
// d_plus to any output.
//
// Parameters
//   RST_VAL   : level loaded into both history flops on reset.
//               The default 1'b1 is the USB idle J-state (D+ high).
//
// Ports
//   clk       in   system clock; all state updates on the rising edge
//   rst       in   synchronous, active-high reset
//   d_plus    in   raw D+ level, already synchronous to clk
//   d_edge    out  one-cycle pulse when the registered level changed
//   d_rise    out  one-cycle pulse on a 0->1 change
//   d_fall    out  one-cycle pulse on a 1->0 change
//   d_plus_q  out  registered line level
// ---------------------------------------------------------------------------
module edge_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus,
   output logic d_edge,
   output logic d_rise,
   output logic d_fall,
   output logic d_plus_q
);

   logic cur_q;
   logic prev_q;

   // Two-deep line history. Both stages are reset to the idle level, so no
   // pulse is produced while reset is held. If the line is not idle when
   // reset is released, exactly one pulse follows on the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         cur_q  <= d_plus;
         prev_q <= cur_q;
      end
   end

   // Decode edge qualifiers from the history flops only.
   // d_rise and d_fall are disjoint by construction, and their OR is d_edge.
   always_comb begin
      d_edge   = cur_q ^ prev_q;
      d_rise   = cur_q & ~prev_q;
      d_fall   = ~cur_q & prev_q;
      d_plus_q = cur_q;
   end

endmodule

// File: tb/tb_edge_detect.sv
module tb_edge_detect;

   localparam logic RST_VAL = 1'b1;

   logic clk;
   logic rst;
   logic d_plus;
   logic d_edge;
   logic d_rise;
   logic d_fall;
   logic d_plus_q;

   int checks;
   int failures;

   edge_detect #(.RST_VAL(RST_VAL)) dut (
      .clk      (clk),
      .rst      (rst),
      .d_plus   (d_plus),
      .d_edge   (d_edge),
      .d_rise   (d_rise),
      .d_fall   (d_fall),
      .d_plus_q (d_plus_q)
   );

   // Clock: rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One vector = inputs applied for one cycle, then the outputs expected
   // just after that rising edge. exp = {edge, rise, fall, level}.
   typedef struct {
      logic       rst;
      logic       d;
      logic [3:0] exp;
   } vec_t;

   localparam int NVEC = 37;
   vec_t vecs [NVEC];

   // Behavioural model: a list of the line levels seen at each rising edge.
   // A reset wipes the history and replaces it with two idle levels.
   logic hist [$];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive the inputs on the falling edge, then sample 1 time unit after
   // the next rising edge.
   task automatic cycle(input logic r, input logic d);
      @(negedge clk);
      rst    = r;
      d_plus = d;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(input logic r, input logic d);
      if (r) begin
         hist.delete();
         hist.push_back(RST_VAL);
         hist.push_back(RST_VAL);
      end else begin
         hist.push_back(d);
         if (hist.size() > 2) void'(hist.pop_front());
      end
   endtask

   task automatic check_model(input string tag);
      logic now_lvl;
      logic old_lvl;
      now_lvl = hist[hist.size() - 1];
      old_lvl = hist[hist.size() - 2];
      chk({tag, "_edge"},  d_edge,   (now_lvl != old_lvl) ? 1'b1 : 1'b0);
      chk({tag, "_rise"},  d_rise,   (now_lvl == 1'b1 && old_lvl == 1'b0) ? 1'b1 : 1'b0);
      chk({tag, "_fall"},  d_fall,   (now_lvl == 1'b0 && old_lvl == 1'b1) ? 1'b1 : 1'b0);
      chk({tag, "_level"}, d_plus_q, now_lvl);
      chk({tag, "_excl"},  d_rise & d_fall, 1'b0);
      chk({tag, "_or"},    d_edge, d_rise | d_fall);
   endtask

   initial begin
      logic r;
      logic d;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      d_plus   = 1'b0;

      vecs = '{
         // reset held 2 cycles with d_plus=0
         '{1'b1, 1'b0, 4'b0001},
         '{1'b1, 1'b0, 4'b0001},
         // release with line at 0: single release pulse, then stable
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         '{1'b0, 1'b0, 4'b0000},
         // 0->1 step, then stable high
         '{1'b0, 1'b1, 4'b1101},
         '{1'b0, 1'b1, 4'b0001},
         // directed pairs (0,0),(1,0),(0,1),(1,1),(0,0)
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         '{1'b0, 1'b1, 4'b1101},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         '{1'b0, 1'b1, 4'b1101},
         '{1'b0, 1'b1, 4'b0001},
         '{1'b0, 1'b1, 4'b0001},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         // continuous toggle
         '{1'b0, 1'b1, 4'b1101},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b1, 4'b1101},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b1, 4'b1101},
         // fall detect: stable 1, 1->0, stable 0
         '{1'b0, 1'b1, 4'b0001},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         '{1'b0, 1'b0, 4'b0000},
         // reset clears an active pulse and holds outputs quiet
         '{1'b1, 1'b0, 4'b0001},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b1, 1'b0, 4'b0001},
         '{1'b1, 1'b1, 4'b0001},
         '{1'b0, 1'b0, 4'b1010},
         '{1'b0, 1'b0, 4'b0000},
         // release at idle level: no pulse; pending change swallowed by reset
         '{1'b1, 1'b1, 4'b0001},
         '{1'b0, 1'b1, 4'b0001},
         '{1'b1, 1'b0, 4'b0001},
         '{1'b1, 1'b0, 4'b0001},
         '{1'b0, 1'b1, 4'b0001}
      };

      // Table-driven phase
      for (int i = 0; i < NVEC; i++) begin
         cycle(vecs[i].rst, vecs[i].d);
         chk($sformatf("vec%0d_edge", i),  d_edge,   vecs[i].exp[3]);
         chk($sformatf("vec%0d_rise", i),  d_rise,   vecs[i].exp[2]);
         chk($sformatf("vec%0d_fall", i),  d_fall,   vecs[i].exp[1]);
         chk($sformatf("vec%0d_level", i), d_plus_q, vecs[i].exp[0]);
      end

      // Hand-written: a glitch that misses the rising edge is not seen.
      // The line is stable high here, after the last vector.
      cycle(1'b0, 1'b1);
      @(negedge clk);
      d_plus = 1'b1;
      #1 d_plus = 1'b0;
      #2 d_plus = 1'b1;
      @(posedge clk);
      #1;
      chk("glitch_edge",  d_edge,   1'b0);
      chk("glitch_level", d_plus_q, 1'b1);

      // Hand-written: outputs do not follow d_plus between edges.
      #1 d_plus = 1'b0;
      #1;
      chk("nocomb_edge",  d_edge,   1'b0);
      chk("nocomb_level", d_plus_q, 1'b1);
      // The change is picked up at the next edge and lasts one cycle.
      @(posedge clk);
      #1;
      chk("late_fall", d_fall, 1'b1);
      chk("late_edge", d_edge, 1'b1);
      cycle(1'b0, 1'b0);
      chk("late_edge_gone", d_edge, 1'b0);

      // Randomised phase against the history model. The first cycle is a
      // reset so the model starts from a known state.
      for (int n = 0; n < 400; n++) begin
         r = (n == 0) ? 1'b1 : (($urandom_range(15) == 0) ? 1'b1 : 1'b0);
         d = ($urandom_range(3) == 0) ? ~d_plus : (($urandom_range(1) == 0) ? d_plus : 1'b1);
         cycle(r, d);
         model_step(r, d);
         check_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
